// File: rtl/pokey_pkg.sv
// rtl/pokey_pkg.sv - shared types and constants for the POKEY interrupt responder
package pokey_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_PICK,
    S_CLR,
    S_HOLD,
    S_RST,
    S_GUARD,
    S_DLV
  } state_t;

  localparam logic [3:0] POKEY_IRQ_ADDR = 4'hE;

  localparam logic [2:0] SRC_BRK  = 3'd7;
  localparam logic [2:0] SRC_KEY  = 3'd6;
  localparam logic [2:0] SRC_SDI  = 3'd5;
  localparam logic [2:0] SRC_SDO  = 3'd4;
  localparam logic [2:0] SRC_SDOF = 3'd3;
  localparam logic [2:0] SRC_T4   = 3'd2;
  localparam logic [2:0] SRC_T2   = 3'd1;
  localparam logic [2:0] SRC_T1   = 3'd0;

endpackage

// File: rtl/pokey_irq_responder_if.sv
// rtl/pokey_irq_responder_if.sv - POKEY register bus plus acknowledged-source handshake
interface pokey_irq_responder_if;
  logic [3:0] bus_addr;
  logic       bus_re;
  logic       bus_we;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       src_vld;
  logic [2:0] src_idx;
  logic       src_rdy;

  modport master (
    output bus_addr, bus_re, bus_we, bus_wdata, src_vld, src_idx,
    input  bus_rdata, src_rdy
  );

  modport slave (
    input  bus_addr, bus_re, bus_we, bus_wdata, src_vld, src_idx,
    output bus_rdata, src_rdy
  );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - 8-to-3 highest-set-bit encoder with a none-set flag
module irq_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       none
);
  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    idx  = 3'd0;
    none = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        idx  = 3'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/pokey_irq_responder.sv
// rtl/pokey_irq_responder.sv - services POKEY IRQ: read IRQST, ack one source, hand off index
// Optional spurious-interrupt counter: POKEY_IRQ_SPURIOUS_CNT_EN
module pokey_irq_responder
  import pokey_pkg::*;
#(
  parameter int unsigned CLR_HOLD = 4,
  parameter int unsigned GUARD    = 8,
  parameter logic [3:0]  IRQ_ADDR = POKEY_IRQ_ADDR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         irq,
  input  logic [7:0]                   en_mask,
  pokey_irq_responder_if.master        irq_bus,
  output logic                         busy,
  output logic [7:0]                   spur_cnt
);

  state_t     state, state_n;
  logic [7:0] stat, shadow;
  logic [7:0] cnt, cnt_n;
  logic [7:0] wdata_q, wdata_n;
  logic [3:0] addr_q;
  logic       re_q, re_n, we_q, we_n;
  logic       vld_q, vld_n;
  logic [2:0] idx_q, idx_n;
  logic [2:0] pick_q, pick_n;
  logic       picked, picked_n;
  logic       busy_q;

  logic [7:0] pend;
  logic [2:0] enc_idx;
  logic       enc_none;

  // IRQST is active-low; bit 3 is a serial-busy level, never a serviceable request.
  assign pend = ~stat & en_mask & ~(8'b1 << SRC_SDOF);

  irq_prio_enc u_prio (
    .req  (pend),
    .idx  (enc_idx),
    .none (enc_none)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    re_n     = 1'b0;
    we_n     = 1'b0;
    wdata_n  = wdata_q;
    vld_n    = 1'b0;
    idx_n    = idx_q;
    pick_n   = pick_q;
    picked_n = picked;
    case (state)
      S_IDLE: begin
        if (irq) begin
          state_n = S_RD;
          re_n    = 1'b1;
        end
      end
      S_RD:   state_n = S_CAP;
      S_CAP:  state_n = S_PICK;
      S_PICK: begin
        cnt_n = 8'd0;
        if (enc_none) begin
          state_n  = S_GUARD;
          picked_n = 1'b0;
        end else begin
          state_n  = S_CLR;
          we_n     = 1'b1;
          wdata_n  = en_mask & ~(8'b1 << enc_idx);
          pick_n   = enc_idx;
          picked_n = 1'b1;
        end
      end
      S_CLR: begin
        state_n = S_HOLD;
        cnt_n   = 8'd0;
      end
      S_HOLD: begin
        if (cnt == 8'(CLR_HOLD - 1)) begin
          state_n = S_RST;
          we_n    = 1'b1;
          wdata_n = shadow;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_RST: begin
        state_n = S_GUARD;
        cnt_n   = 8'd0;
      end
      S_GUARD: begin
        if (cnt == 8'(GUARD - 1)) begin
          if (picked) begin
            state_n = S_DLV;
            vld_n   = 1'b1;
            idx_n   = pick_q;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DLV: begin
        if (irq_bus.src_rdy) state_n = S_IDLE;
        else                 vld_n   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      stat    <= 8'd0;
      shadow  <= 8'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 8'd0;
      addr_q  <= 4'd0;
      vld_q   <= 1'b0;
      idx_q   <= 3'd0;
      pick_q  <= 3'd0;
      picked  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      re_q    <= re_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
      addr_q  <= (re_n || we_n) ? IRQ_ADDR : 4'd0;
      vld_q   <= vld_n;
      idx_q   <= idx_n;
      pick_q  <= pick_n;
      picked  <= picked_n;
      busy_q  <= (state_n != S_IDLE);
      if (state == S_CAP)  stat   <= irq_bus.bus_rdata;
      if (state == S_PICK) shadow <= en_mask;
    end
  end

`ifdef POKEY_IRQ_SPURIOUS_CNT_EN
  logic [7:0] spur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spur_q <= 8'd0;
    end else if (state == S_PICK && enc_none && spur_q != 8'hFF) begin
      spur_q <= spur_q + 8'd1;
    end
  end

  assign spur_cnt = spur_q;
`else
  assign spur_cnt = 8'h00;
`endif

  assign irq_bus.bus_addr  = addr_q;
  assign irq_bus.bus_re    = re_q;
  assign irq_bus.bus_we    = we_q;
  assign irq_bus.bus_wdata = wdata_q;
  assign irq_bus.src_vld   = vld_q;
  assign irq_bus.src_idx   = idx_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_pokey_irq_responder.sv
// tb/tb_pokey_irq_responder.sv - scoreboard bench with a small POKEY IRQST/IRQEN model
module tb_pokey_irq_responder;

`ifdef POKEY_IRQ_SPURIOUS_CNT_EN
  localparam int SPUR_ONE = 1;
  localparam int SPUR_SAT = 255;
`else
  localparam int SPUR_ONE = 0;
  localparam int SPUR_SAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       irq;
  logic [7:0] en_mask;
  logic       busy;
  logic [7:0] spur_cnt;

  pokey_irq_responder_if bif ();

  pokey_irq_responder #(.CLR_HOLD(4), .GUARD(8), .IRQ_ADDR(4'hE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .en_mask  (en_mask),
    .irq_bus  (bif),
    .busy     (busy),
    .spur_cnt (spur_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // POKEY model: IRQST active-low, writing IRQEN with a bit clear releases that request
  logic [7:0] irqst = 8'hFF;
  logic [7:0] irqen = 8'h00;
  logic       sw_req = 1'b0;
  logic [7:0] sw_st = 8'hFF;
  logic [7:0] sw_en = 8'h00;
  logic       force_irq = 1'b0;

  assign irq = (|(~irqst & irqen & 8'hF7)) | force_irq;

  initial bif.bus_rdata = 8'h00;
  always @(posedge clk) begin
    bif.bus_rdata <= bif.bus_re ? irqst : 8'h00;
    if (sw_req) begin
      irqst <= sw_st;
      irqen <= sw_en;
    end else if (bif.bus_we) begin
      irqen <= bif.bus_wdata;
      irqst <= irqst | (~bif.bus_wdata & 8'hF7);
    end
  end

  // Expected-event FIFO: kind 0 = IRQEN write, kind 1 = delivered source index
  logic       exp_kind [0:63];
  logic [7:0] exp_val  [0:63];
  int         exp_wr = 0;
  int         exp_rd = 0;

  string chk_name = "";
  int    chk_got  = 0;
  int    chk_exp  = 0;
  int    chk_seq  = 0;
  int    chk_done = 0;

  int tests = 0;
  int fails = 0;
  int re_count = 0;
  int we_count = 0;
  int dlv_count = 0;
  int vld_rise_cyc = 0;
  logic       prev_vld = 1'b0;
  logic [2:0] prev_idx = 3'd0;

  task automatic pop_check(input logic kind, input logic [7:0] val, input string name);
    tests++;
    if (exp_rd == exp_wr) begin
      fails++;
      $display("FAIL %s unexpected event got %02h expected none", name, val);
    end else begin
      if (exp_kind[exp_rd % 64] != kind || exp_val[exp_rd % 64] != val) begin
        fails++;
        $display("FAIL %s got kind %0d val %02h expected kind %0d val %02h",
                 name, kind, val, exp_kind[exp_rd % 64], exp_val[exp_rd % 64]);
      end
      exp_rd++;
    end
  endtask

  always @(negedge clk) begin
    tests++;
    if (bif.bus_re && bif.bus_we) begin
      fails++;
      $display("FAIL strobe_excl got re=1 we=1 expected at most one");
    end
    tests++;
    if (bif.bus_addr != ((bif.bus_re || bif.bus_we) ? 4'hE : 4'h0)) begin
      fails++;
      $display("FAIL bus_addr got %h expected %h", bif.bus_addr,
               (bif.bus_re || bif.bus_we) ? 4'hE : 4'h0);
    end
    if (bif.bus_re) re_count++;
    if (bif.bus_we) begin
      we_count++;
      pop_check(1'b0, bif.bus_wdata, "irqen_write");
    end
    if (bif.src_vld) begin
      if (!prev_vld) vld_rise_cyc = cyc;
      tests++;
      if (bif.bus_re || bif.bus_we) begin
        fails++;
        $display("FAIL dlv_quiet got strobe during src_vld expected none");
      end
      if (prev_vld) begin
        tests++;
        if (bif.src_idx != prev_idx) begin
          fails++;
          $display("FAIL idx_stable got %0d expected %0d", bif.src_idx, prev_idx);
        end
      end
      if (bif.src_rdy) begin
        dlv_count++;
        pop_check(1'b1, {5'd0, bif.src_idx}, "src_deliver");
      end
    end else if (prev_vld) begin
      tests++;
      fails++;
      $display("FAIL vld_stable got src_vld=0 expected 1 until accepted");
    end
    prev_vld = bif.src_vld && !bif.src_rdy;
    prev_idx = bif.src_idx;
    if (chk_seq != chk_done) begin
      tests++;
      if (chk_got != chk_exp) begin
        fails++;
        $display("FAIL %s got %0h expected %0h", chk_name, chk_got, chk_exp);
      end
      chk_done = chk_seq;
    end
  end

  function automatic int outs_packed();
    return int'({bif.bus_addr, bif.bus_re, bif.bus_we, bif.bus_wdata,
                 bif.src_vld, bif.src_idx, busy, spur_cnt});
  endfunction

  task automatic req_check(input string name, input int got, input int exp);
    chk_name = name;
    chk_got  = got;
    chk_exp  = exp;
    chk_seq++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic kind, input logic [7:0] val);
    exp_kind[exp_wr % 64] = kind;
    exp_val[exp_wr % 64]  = val;
    exp_wr++;
  endtask

  task automatic pokey_set(input logic [7:0] st, input logic [7:0] en);
    sw_st  = st;
    sw_en  = en;
    sw_req = 1'b1;
    @(posedge clk);
    #1;
    sw_req = 1'b0;
  endtask

  task automatic wait_dlv(input int target, input string name);
    int t = 0;
    while (dlv_count < target && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    req_check(name, dlv_count, target);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    req_check(name, int'(busy), 0);
  endtask

  initial begin
    int start;
    int r0;
    int t;
    rst_n       = 1'b0;
    en_mask     = 8'h00;
    bif.src_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_check("reset_values", outs_packed(), 0);
    rst_n = 1'b1;

    // Timer 1 alone
    en_mask = 8'h01;
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'h01);
    push_exp(1'b1, 8'h00);
    r0 = re_count;
    pokey_set(8'hFE, 8'h01);
    start = cyc;
    wait_dlv(1, "t1_deliver");
    req_check("t1_latency", vld_rise_cyc - start, 18);
    repeat (30) @(posedge clk);
    #1;
    req_check("t1_single_read", re_count - r0, 1);
    req_check("t1_idle", int'(busy), 0);

    // Break and key together: two passes in priority order
    en_mask = 8'hFF;
    push_exp(1'b0, 8'h7F);
    push_exp(1'b0, 8'hFF);
    push_exp(1'b1, 8'h07);
    push_exp(1'b0, 8'hBF);
    push_exp(1'b0, 8'hFF);
    push_exp(1'b1, 8'h06);
    pokey_set(8'h3F, 8'hFF);
    wait_dlv(3, "t2_deliver");
    wait_idle("t2_idle");

    // Downstream stalls for 10 cycles in DLV
    bif.src_rdy = 1'b0;
    push_exp(1'b0, 8'hBF);
    push_exp(1'b0, 8'hFF);
    push_exp(1'b1, 8'h06);
    pokey_set(8'hBF, 8'hFF);
    t = 0;
    while (!bif.src_vld && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    req_check("t4_vld_seen", int'(bif.src_vld), 1);
    repeat (10) @(posedge clk);
    #1;
    req_check("t4_hold", int'({bif.src_vld, bif.src_idx}), 'hE);
    bif.src_rdy = 1'b1;
    wait_dlv(4, "t4_deliver");
    wait_idle("t4_idle");

    // Reset during HOLD: no restore write may follow
    push_exp(1'b0, 8'hFB);
    r0 = we_count;
    pokey_set(8'hFB, 8'hFF);
    t = 0;
    while (we_count == r0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    req_check("t5_async_reset", outs_packed(), 0);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    req_check("t5_no_restore", we_count - r0, 1);
    pokey_set(8'hFF, 8'hFF);
    req_check("t5_idle", int'(busy), 0);

    // Spurious: only the serial-busy bit reads low
    pokey_set(8'hF7, 8'hFF);
    r0 = re_count;
    force_irq = 1'b1;
    t = 0;
    while (re_count < r0 + 1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    force_irq = 1'b0;
    wait_idle("t3_idle");
    req_check("t3_spur_one", int'(spur_cnt), SPUR_ONE);

    // 300 more spurious events: counter saturates
    r0 = re_count;
    force_irq = 1'b1;
    t = 0;
    while (re_count < r0 + 300 && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    force_irq = 1'b0;
    req_check("t6_passes", re_count - r0, 300);
    wait_idle("t6_idle");
    req_check("t6_spur_sat", int'(spur_cnt), SPUR_SAT);

    req_check("sb_drain", exp_rd, exp_wr);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
